// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - load/store unit for a word-addressed data memory (option: DMEM_LSU_ALIGN_CHECK_EN)
module dmem_lsu #(
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] mem_rAddr,
   input  logic [31:0]       mem_rDout,
   output logic [ADDR_W-1:0] mem_wAddr,
   output logic [31:0]       mem_wDin,
   output logic              mem_wEna
);

`ifdef DMEM_LSU_ALIGN_CHECK_EN
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RD = 2'd1, S_WR = 2'd2, S_ERR = 2'd3} state_t;
`else
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RD = 2'd1, S_WR = 2'd2} state_t;
`endif

   state_t              state_q, state_d;
   logic                we_q, we_d;
   logic [1:0]          size_q, size_d;
   logic                uns_q, uns_d;
   logic [1:0]          lane_q, lane_d;
   logic [ADDR_W-1:0]   idx_q, idx_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [31:0]         merge_q, merge_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [31:0]         rsp_rdata_q, rsp_rdata_d;
   logic                rsp_err_q, rsp_err_d;

   // Address bits above the memory depth are intentionally ignored.
   logic                unused_addr_hi;
   assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

   // Request size and lane as they will be latched; misaligned flags an error.
   logic [1:0]          size_n;
   logic [1:0]          lane_n;
   logic                misalign;
   logic [7:0]          byte_sel;
   logic [15:0]         half_sel;
   logic [31:0]         ld_data;
   logic [31:0]         merged;

   // Normalise the incoming request (alignment checked or low bits forced to 0).
   always_comb begin
      size_n   = req_size;
      lane_n   = req_addr[1:0];
      misalign = 1'b0;
`ifdef DMEM_LSU_ALIGN_CHECK_EN
      misalign = (req_size == 2'b11)
               || (req_size == 2'b01 && req_addr[0])
               || (req_size == 2'b10 && req_addr[1:0] != 2'b00);
`else
      if (req_size == 2'b11) size_n = 2'b10;
      if (size_n == 2'b01) lane_n = {req_addr[1], 1'b0};
      else if (size_n == 2'b10) lane_n = 2'b00;
`endif
   end

   // Lane extraction with sign/zero extension, and partial-store lane merge.
   always_comb begin
      byte_sel = mem_rDout[{lane_q, 3'b000} +: 8];
      half_sel = lane_q[1] ? mem_rDout[31:16] : mem_rDout[15:0];
      case (size_q)
         2'b00:   ld_data = {{24{~uns_q & byte_sel[7]}}, byte_sel};
         2'b01:   ld_data = {{16{~uns_q & half_sel[15]}}, half_sel};
         default: ld_data = mem_rDout;
      endcase
      merged = mem_rDout;
      if (size_q == 2'b00) merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
      else                 merged[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
   end

   // State and datapath registers; asynchronous reset aborts any operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         we_q        <= 1'b0;
         size_q      <= 2'b00;
         uns_q       <= 1'b0;
         lane_q      <= 2'b00;
         idx_q       <= '0;
         wdata_q     <= 32'd0;
         merge_q     <= 32'd0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'd0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         size_q      <= size_d;
         uns_q       <= uns_d;
         lane_q      <= lane_d;
         idx_q       <= idx_d;
         wdata_q     <= wdata_d;
         merge_q     <= merge_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // Next-state logic: accept in IDLE, read in RD, commit in WR, report in ERR.
   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      size_d      = size_q;
      uns_d       = uns_q;
      lane_d      = lane_q;
      idx_d       = idx_q;
      wdata_d     = wdata_q;
      merge_d     = merge_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               size_d  = size_n;
               uns_d   = req_unsigned;
               lane_d  = lane_n;
               idx_d   = req_addr[ADDR_W+1:2];
               wdata_d = req_wdata;
               if (misalign) begin
`ifdef DMEM_LSU_ALIGN_CHECK_EN
                  state_d = S_ERR;
`endif
               end else if (req_we && size_n == 2'b10) begin
                  merge_d = req_wdata;
                  state_d = S_WR;
               end else begin
                  state_d = S_RD;
               end
            end
         end
         S_RD: begin
            if (we_q) begin
               merge_d = merged;
               state_d = S_WR;
            end else begin
               rsp_valid_d = 1'b1;
               rsp_rdata_d = ld_data;
               state_d     = S_IDLE;
            end
         end
         S_WR: begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = 32'd0;
            state_d     = S_IDLE;
         end
`ifdef DMEM_LSU_ALIGN_CHECK_EN
         S_ERR: begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'd0;
            state_d     = S_IDLE;
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   assign req_ready = (state_q == S_IDLE);
   assign mem_wEna  = (state_q == S_WR);
   assign mem_rAddr = idx_q;
   assign mem_wAddr = idx_q;
   assign mem_wDin  = merge_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
`ifdef DMEM_LSU_ALIGN_CHECK_EN
   assign rsp_err   = rsp_err_q;
`else
   logic unused_err;
   assign unused_err = rsp_err_q;
   assign rsp_err   = 1'b0;
`endif

endmodule
